// File: rtl/mdu_pkg.sv
// Shared MDU definitions: 3-bit op encodings, default busy-cycle counts,
// the latched-request record and small op-class helpers. The MCU decoder
// imports the same package so both sides agree on the encodings.
package mdu_pkg;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    // Operation captured at start and held for the whole busy window
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit divider for the MDU (only built with MDU_DIV_EN).
// Signed ops divide magnitudes and fix signs afterwards: the quotient
// truncates toward zero and the remainder takes the dividend's sign.
// A zero divisor yields zeros; the caller discards the result anyway.
module mdu_div
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_signed = is_signed_op(i_op);
    assign w_neg_a  = w_signed & i_a[31];
    assign w_neg_b  = w_signed & i_b[31];
    // 0x80000000 negates to itself, which is still the right unsigned magnitude
    assign w_mag_a  = w_neg_a ? (~i_a + 32'd1) : i_a;
    assign w_mag_b  = w_neg_b ? (~i_b + 32'd1) : i_b;

    // Unsigned magnitude divide, zero divisor forced to a defined value
    always_comb begin
        w_uq = '0;
        w_ur = '0;
        if (w_mag_b != '0) begin
            w_uq = w_mag_a / w_mag_b;
            w_ur = w_mag_a % w_mag_b;
        end
    end

    assign o_quot = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
    assign o_rem  = w_neg_a ? (~w_ur + 32'd1) : w_ur;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO. A start (MULT/MULTU, and
// DIV/DIVU when MDU_DIV_EN is defined) latches the operands and holds busy
// for MULT_CYCLES/DIV_CYCLES cycles; HI/LO are written at the edge that
// drops busy. MTHI/MTLO write at the next edge when idle; MFHI/MFLO only
// steer rd_data. Without MDU_DIV_EN, DIV/DIVU are no-ops and no divider
// is built.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    mdu_req_t         r_req;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_start;
    logic             w_start_div;
    logic [63:0]      w_ext_a;
    logic [63:0]      w_ext_b;
    logic [63:0]      w_prod;
    logic [63:0]      w_result;
    logic             w_wr;

    assign busy    = (r_state == ST_RUN);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = (op == OP_MFHI) ? r_hi : r_lo;

    // Low 64 bits of the product of the extended operands equal the signed
    // or unsigned 32x32 product, so one multiplier serves both ops.
    assign w_ext_a = is_signed_op(r_req.op) ? {{32{r_req.a[31]}}, r_req.a} : {32'b0, r_req.a};
    assign w_ext_b = is_signed_op(r_req.op) ? {{32{r_req.b[31]}}, r_req.b} : {32'b0, r_req.b};
    assign w_prod  = w_ext_a * w_ext_b;

`ifdef MDU_DIV_EN
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    mdu_div u_div (
        .i_op   (r_req.op),
        .i_a    (r_req.a),
        .i_b    (r_req.b),
        .o_quot (w_quot),
        .o_rem  (w_rem)
    );

    assign w_start_div = is_div_op(op);
    assign w_result    = is_mul_op(r_req.op) ? w_prod : {w_rem, w_quot};
    // Divide by zero still burns the full latency but leaves HI/LO alone
    assign w_wr        = is_mul_op(r_req.op) || (r_req.b != '0);
`else
    assign w_start_div = 1'b0;
    assign w_result    = w_prod;
    assign w_wr        = 1'b1;
`endif

    assign w_start = en && (r_state == ST_IDLE) && (is_mul_op(op) || w_start_div);

    // IDLE/RUN control, cycle counter, operand latch and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_req   <= '{op: op, a: src_a, b: src_b};
                        r_cnt   <= is_mul_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_state <= ST_RUN;
                    end else if (en && op == OP_MTHI) begin
                        r_hi <= src_a;
                    end else if (en && op == OP_MTLO) begin
                        r_lo <= src_a;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (w_wr) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu. A behavioural HI/LO model uses
// plain 64-bit arithmetic; busy duration is measured by counting cycles.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mdu;
    import mdu_pkg::*;

    localparam int EXP_MULT = 5;
    localparam int EXP_DIV  = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  op = OP_MFLO;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result of a multiply/divide, straight from the arithmetic rules
    task automatic model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        longint      q;
        longint      r;
        case (o)
            OP_MULT: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                {m_hi, m_lo} = sp;
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                {m_hi, m_lo} = up;
            end
            OP_DIV: if (b != 0) begin
                q = longint'(int'(a)) / longint'(int'(b));
                r = longint'(int'(a)) % longint'(int'(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            OP_DIVU: if (b != 0) begin
                up = 64'(a) / 64'(b);
                m_lo = up[31:0];
                up = 64'(a) % 64'(b);
                m_hi = up[31:0];
            end
            default: ;
        endcase
    endtask

    // Present one instruction for one cycle (called at a falling edge, idle),
    // then follow it to completion and compare against the model.
    task automatic issue(input logic e, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int  n;
        bit  starts;
        bit  is_mul;
        is_mul = (o == OP_MULT) || (o == OP_MULTU);
        starts = e && (is_mul || (DIV_ON && (o == OP_DIV || o == OP_DIVU)));
        en = e; op = o; src_a = a; src_b = b;
        #1;
        chk("rd_data", rd_data, (o == OP_MFHI) ? m_hi : m_lo);
        @(negedge clk);
        en = 1'b0; op = OP_MFLO;
        if (starts) begin
            n = 0;
            while (busy && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("busy_cycles", 32'(n), 32'(is_mul ? EXP_MULT : EXP_DIV));
            model_result(o, a, b);
        end else begin
            chk("busy_idle", {31'b0, busy}, 32'd0);
            if (e && o == OP_MTHI) m_hi = a;
            if (e && o == OP_MTLO) m_lo = a;
        end
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    initial begin
        int n;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        re;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;

        // Directed multiplies
        issue(1'b1, OP_MULT,  32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFFA);
        issue(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // Move-to with en low is ignored; move-to/from while idle
        issue(1'b0, OP_MTLO, 32'h5555_5555, 32'd0);
        issue(1'b1, OP_MTHI, 32'hCAFE_0001, 32'd0);
        issue(1'b1, OP_MFHI, 32'd0, 32'd0);

        // Start and MTLO while busy are both dropped
        en = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        chk("ign_busy1", {31'b0, busy}, 32'd1);
        en = 1'b1; op = OP_MULT; src_a = 32'd100; src_b = 32'd100;
        @(negedge clk);
        chk("ign_busy2", {31'b0, busy}, 32'd1);
        en = 1'b1; op = OP_MTLO; src_a = 32'h1234;
        @(negedge clk);
        en = 1'b0; op = OP_MFLO;
        chk("ign_mtlo", lo, m_lo);
        n = 3;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ign_cycles", 32'(n), 32'(EXP_MULT));
        m_hi = 32'd0; m_lo = 32'd63;
        chk("ign_hi", hi, m_hi);
        chk("ign_lo", lo, m_lo);
        @(negedge clk);
        chk("ign_no_restart", {31'b0, busy}, 32'd0);
        issue(1'b1, OP_MTLO, 32'h1234, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        op = OP_MFLO; #1;
        chk("mflo_rd", rd_data, 32'h1234);

        // Divide path (or its absence)
`ifdef MDU_DIV_EN
        issue(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(1'b1, OP_DIVU, 32'd5, 32'd0);
        issue(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, OP_DIV, 32'd7, 32'hFFFF_FFFE);
`else
        issue(1'b1, OP_DIV,  32'd8, 32'd2);
        issue(1'b1, OP_DIVU, 32'd8, 32'd2);
`endif

        // Reset in the 3rd busy cycle of MULT 4x4 aborts it
        issue(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        en = 1'b1; op = OP_MULT; src_a = 32'd4; src_b = 32'd4;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_busy_after", {31'b0, busy}, 32'd0);
        chk("abort_hi_after", hi, 32'd0);
        chk("abort_lo_after", lo, 32'd0);

        // Start accepted on the first edge after reset release
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue(1'b1, OP_MULTU, 32'h0001_0000, 32'h0003_0000);

        // Randomized mix, with occasional corner operands
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            re = ($urandom_range(0, 4) != 0);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(re, ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving busy cycles per MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving busy cycles per DIV/DIVU.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit; E-stage instruction is an MDU op this cycle.
REQ-006 SHALL have port op, input, 3 bits; MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 SHALL have port src_a, input, 32 bits; forwarded rs value (E_SrcA).
REQ-008 SHALL have port src_b, input, 32 bits; forwarded rt value (E_SrcB_temp).
REQ-009 SHALL have port busy, output, 1 bit; operation in flight.
REQ-010 SHALL have port rd_data, output, 32 bits; HI when op=MFHI, otherwise LO; combinational.
REQ-011 SHALL have port hi, output, 32 bits; architectural HI.
REQ-012 SHALL have port lo, output, 32 bits; architectural LO.

Function
REQ-013 SHALL define a start as en=1 with op in {MULT,MULTU,DIV,DIVU} and busy=0, sampled at a rising edge.
REQ-014 SHALL latch operands and op on start, load the counter with MULT_CYCLES or DIV_CYCLES, and assert busy from the following cycle.
REQ-015 SHALL decrement the counter each edge while busy, deassert busy at the edge where the counter reaches 1, and write HI/LO at that same edge.
REQ-016 SHALL use a state machine with states IDLE -> RUN (on start) -> IDLE (on counter reaching 1); there is no other state.
REQ-017 SHALL compute MULT as a signed 64-bit product and MULTU as an unsigned one, with HI=[63:32] and LO=[31:0].
REQ-018 SHALL compute DIV/DIVU with LO=quotient and HI=remainder, truncating toward zero; the remainder sign follows the dividend.
REQ-019 SHALL still run divide-by-zero for the full DIV_CYCLES and SHALL leave HI/LO unchanged.
REQ-020 SHALL ignore a start request while busy=1; the hazard unit stalls D on busy or on a pending start.
REQ-021 SHALL write HI (MTHI) or LO (MTLO) from src_a at the next edge only when en=1 and busy=0; such writes are ignored while busy.
REQ-022 SHALL treat MFHI/MFLO as purely combinational and SHALL NOT modify state.
REQ-023 SHALL ignore op entirely when en=0.

Reset
REQ-024 SHALL, while reset=0, force busy=0, counter=0, hi=0, lo=0, state=IDLE and clear latched operands, asynchronously.
REQ-025 SHALL abort any in-flight operation on reset without writing its result.
REQ-026 SHALL accept a start at the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL compile the divide path in only when macro MDU_DIV_EN is defined.
REQ-028 SHALL, with MDU_DIV_EN undefined, treat DIV/DIVU as no-ops: no busy, HI/LO unchanged, and no divider hardware present.

Structure
REQ-029 SHALL take op encodings (3-bit), MULT_CYCLES and DIV_CYCLES defaults from the shared package, which the MCU also uses.
REQ-030 SHALL place the divider in sub-module mdu_div (combinational signed/unsigned quotient and remainder), instantiated only under MDU_DIV_EN.
REQ-031 SHALL keep the counter, state machine, and HI/LO registers in mdu itself.

Verification
REQ-032 SHALL pass: MULT src_a=0xFFFFFFFE, src_b=3 -> busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 SHALL pass: MULTU 0xFFFFFFFF x 2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 SHALL pass (MDU_DIV_EN defined): DIV -7/2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> busy for 10 cycles, HI/LO unchanged.
REQ-035 SHALL pass: reset=0 in the 3rd busy cycle of MULT 4x4 -> busy=0 and HI=LO=0 immediately, and remain 0 after release.
REQ-036 SHALL pass: MULT issued while busy, and MTLO 0x1234 while busy -> both ignored; MTLO 0x1234 when idle -> LO=0x1234 next cycle, and MFLO rd_data=0x1234.
REQ-037 SHALL pass (MDU_DIV_EN undefined): DIV 8/2 -> busy stays 0 and HI/LO are unchanged.
